// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module  : instruction_fetch_unit_pkg
// Brief   : Shared FSM state encoding and default widths for the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_unit_pkg;

  localparam int DEFAULT_INSTRUCTION_LEN      = 16;
  localparam int DEFAULT_INSTRUCTION_MEM_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_active(input fetch_state_t s);
    return (s == FETCH) || (s == HOLD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_reg.sv
// ============================================================================
// Module  : fetch_pc_reg
// Brief   : Program counter with redirect (priority) and modulo increment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             increment,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_VAL;
    end else if (redirect) begin
      pc <= target;
    end else if (increment) begin
      // Natural wrap of the WIDTH-bit add gives modulo-2**WIDTH addressing.
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module  : instruction_fetch_unit
// Brief   : Fetch FSM and instruction register feeding a ready/valid decoder.
//           Macro FETCH_PREFETCH_EN enables the ipr_write prefetch request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                                INSTRUCTION_LEN      = DEFAULT_INSTRUCTION_LEN,
  parameter int                                INSTRUCTION_MEM_SIZE = DEFAULT_INSTRUCTION_MEM_SIZE,
  parameter logic [INSTRUCTION_MEM_SIZE-1:0]   RESET_PC             = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            halt,
  output logic [INSTRUCTION_MEM_SIZE-1:0] instruction_ptr,
  output logic                            ipr_write,
  input  logic [INSTRUCTION_LEN-1:0]      instruction,
  output logic [INSTRUCTION_LEN-1:0]      ir,
  output logic [INSTRUCTION_MEM_SIZE-1:0] ir_pc,
  output logic                            ir_valid,
  input  logic                            ir_ready,
  input  logic                            branch_taken,
  input  logic [INSTRUCTION_MEM_SIZE-1:0] branch_target,
  output logic                            busy
);

  fetch_state_t                    state;
  fetch_state_t                    state_next;
  logic                            active;
  logic                            load;
  logic                            redirect;
  logic                            flush;
  logic [INSTRUCTION_MEM_SIZE-1:0] pc;

  // Priority inside FETCH/HOLD: halt > branch_taken > load.
  assign active   = is_active(state);
  assign flush    = active && (halt || branch_taken);
  assign redirect = active && !halt && branch_taken;
  assign load     = active && !flush && (!ir_valid || ir_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALTED: begin
        if (start) state_next = FETCH;
      end
      FETCH, HOLD: begin
        if (halt)              state_next = HALTED;
        else if (branch_taken) state_next = FETCH;
        else if (load)         state_next = FETCH;
        else                   state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = active;
    ipr_write = 1'b0;
`ifdef FETCH_PREFETCH_EN
    // HOLD implies ir_valid, so ready low here can never coincide with a load.
    ipr_write = (state == HOLD) && !ir_ready;
`endif
  end

  fetch_pc_reg #(
    .WIDTH     (INSTRUCTION_MEM_SIZE),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .redirect  (redirect),
    .target    (branch_target),
    .increment (load),
    .pc        (pc)
  );

  assign instruction_ptr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (load) begin
      ir       <= instruction;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
